// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - shares one program-memory cache port among several fetch consumers
//
// Purpose: grants one consumer at a time onto the cache read port, relays the
// returned instruction word back to that consumer, then waits out the cache
// handshake before arbitrating again. All outputs are registered.
//
// Configuration macro: PMEM_ARB_ROUND_ROBIN_EN
//   defined   - round-robin grant starting at rr_ptr
//   undefined - fixed priority, lowest index wins (rr_ptr still tracked)
//
// Ports:
//   i_clk                    clock, all state on rising edge
//   i_reset                  asynchronous active-high reset
//   i_consumer_read_valid    per-consumer fetch request
//   i_consumer_read_address  per-consumer fetch address, consumer k at [k*ADDR_BITS +: ADDR_BITS]
//   o_consumer_read_ready    per-consumer response strobe
//   o_consumer_read_data     per-consumer instruction, consumer k at [k*DATA_BITS +: DATA_BITS]
//   o_cache_read_valid       request to the cache
//   o_cache_read_address     address presented to the cache
//   i_cache_read_ready       cache response strobe
//   i_cache_read_data        cache response word
//   o_busy                   high whenever the FSM is not IDLE

module pmem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 2
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [NUM_CONSUMERS-1:0]           i_consumer_read_valid,
    input  logic [ADDR_BITS*NUM_CONSUMERS-1:0] i_consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           o_consumer_read_ready,
    output logic [DATA_BITS*NUM_CONSUMERS-1:0] o_consumer_read_data,
    output logic                               o_cache_read_valid,
    output logic [ADDR_BITS-1:0]               o_cache_read_address,
    input  logic                               i_cache_read_ready,
    input  logic [DATA_BITS-1:0]               i_cache_read_data,
    output logic                               o_busy
);

    localparam int OWNER_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, REQ, RELAY, DRAIN} state_t;

    state_t                             r_state;
    logic [OWNER_BITS-1:0]              r_owner;
    logic [OWNER_BITS-1:0]              r_rr_ptr;
    logic [NUM_CONSUMERS-1:0]           r_consumer_read_ready;
    logic [DATA_BITS*NUM_CONSUMERS-1:0] r_consumer_read_data;
    logic                               r_cache_read_valid;
    logic [ADDR_BITS-1:0]               r_cache_read_address;
    logic                               r_busy;

    logic [OWNER_BITS-1:0]              w_grant;
    logic [ADDR_BITS-1:0]               w_grant_address;
    logic [OWNER_BITS-1:0]              w_rr_ptr_next;
    logic                               w_owner_valid;

    assign o_consumer_read_ready = r_consumer_read_ready;
    assign o_consumer_read_data  = r_consumer_read_data;
    assign o_cache_read_valid    = r_cache_read_valid;
    assign o_cache_read_address  = r_cache_read_address;
    assign o_busy                = r_busy;

    assign w_owner_valid = i_consumer_read_valid[r_owner];

    // Grant selection. Both loops scan from the far end down so the last
    // match written is the highest-priority candidate.
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        int idx;
        idx     = 0;
        w_grant = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CONSUMERS) begin
                idx = idx - NUM_CONSUMERS;
            end
            if (i_consumer_read_valid[idx]) begin
                w_grant = OWNER_BITS'(idx);
            end
        end
    end
`else
    always_comb begin
        w_grant = '0;
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            if (i_consumer_read_valid[k]) begin
                w_grant = OWNER_BITS'(k);
            end
        end
    end
`endif

    always_comb begin
        w_grant_address = '0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            if (OWNER_BITS'(k) == w_grant) begin
                w_grant_address = i_consumer_read_address[k*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    // The pointer advances past the owner when its transaction retires, so
    // the just-served consumer becomes lowest priority for the next scan.
    always_comb begin
        w_rr_ptr_next = r_rr_ptr;
        if (r_state == RELAY && !w_owner_valid) begin
            w_rr_ptr_next = (int'(r_owner) == NUM_CONSUMERS - 1) ? '0 : r_owner + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state               <= IDLE;
            r_owner               <= '0;
            r_rr_ptr              <= '0;
            r_consumer_read_ready <= '0;
            r_consumer_read_data  <= '0;
            r_cache_read_valid    <= 1'b0;
            r_cache_read_address  <= '0;
            r_busy                <= 1'b0;
        end else begin
            r_rr_ptr <= w_rr_ptr_next;
            case (r_state)
                IDLE: begin
                    if (|i_consumer_read_valid) begin
                        r_cache_read_address <= w_grant_address;
                        r_cache_read_valid   <= 1'b1;
                        r_owner              <= w_grant;
                        r_busy               <= 1'b1;
                        r_state              <= REQ;
                    end
                end
                REQ: begin
                    // Completes even if the owner has already dropped valid;
                    // RELAY then retires it after a single ready cycle.
                    if (i_cache_read_ready) begin
                        r_cache_read_valid <= 1'b0;
                        for (int k = 0; k < NUM_CONSUMERS; k++) begin
                            if (OWNER_BITS'(k) == r_owner) begin
                                r_consumer_read_ready[k]                    <= 1'b1;
                                r_consumer_read_data[k*DATA_BITS +: DATA_BITS] <= i_cache_read_data;
                            end
                        end
                        r_state <= RELAY;
                    end
                end
                RELAY: begin
                    // Only the owner's lanes can be nonzero, so clearing all is
                    // equivalent to clearing the owner's.
                    if (!w_owner_valid) begin
                        r_consumer_read_ready <= '0;
                        r_consumer_read_data  <= '0;
                        if (i_cache_read_ready) begin
                            r_state <= DRAIN;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (!i_cache_read_ready) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
